imem_arbiter: RTL



---
 rtl/imem_arbiter_pkg.sv | 13 +
 rtl/imem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/imem_arbiter_pkg.sv
// RV32I shared definitions: IMEM read-return owner encoding and the canonical NOP word.
package RV32I_definitions;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_IF   = 2'd1,
      OWNER_LD   = 2'd2
   } rd_owner_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/imem_arbiter.sv
// IMEM arbiter (fetch vs loader): combinational grant, read data 1 cycle after grant; no gnt means the requester holds.
// IMEM_ARB_RANGE_CHECK_EN adds addr_err, which turns out-of-range accesses into NOP reads and dropped writes.
module imem_arbiter
   import RV32I_definitions::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int IMEM_DATA_DEPTH = 1024,
   parameter int LD_BURST_MAX    = 4,
   localparam int MW             = $clog2(IMEM_DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [31:0]           if_rdata,
   input  logic                  ld_req,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [31:0]           ld_wdata,
   output logic                  ld_gnt,
   output logic                  ld_rvalid,
   output logic [31:0]           ld_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [MW-1:0]         mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
`ifdef IMEM_ARB_RANGE_CHECK_EN
   ,output logic                 addr_err
`endif
);

   localparam int CW = $clog2(LD_BURST_MAX + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(LD_BURST_MAX);

   rd_owner_t     rd_owner, rd_owner_next;
   logic [CW-1:0] burst_cnt;
   logic          burst_full;
   logic [MW-1:0] if_idx, ld_idx;
   logic          if_bad, ld_bad;
   logic          rd_err;
   logic [31:0]   ret_data;
   logic          unused_addr_lsbs;

   assign if_idx           = if_addr[MW+1:2];
   assign ld_idx           = ld_addr[MW+1:2];
   assign unused_addr_lsbs = ^{if_addr[1:0], ld_addr[1:0]};
   assign burst_full       = (burst_cnt == BURST_MAX);

`ifdef IMEM_ARB_RANGE_CHECK_EN
   logic err_q;

   assign if_bad = (|if_addr[ADDR_WIDTH-1:MW+2]) || (32'(if_idx) >= 32'(IMEM_DATA_DEPTH));
   assign ld_bad = (|ld_addr[ADDR_WIDTH-1:MW+2]) || (32'(ld_idx) >= 32'(IMEM_DATA_DEPTH));

   // Error flag rides alongside rd_owner so it lands in the same slot as rvalid.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) err_q <= 1'b0;
      else         err_q <= (if_gnt && if_bad) || (ld_gnt && ld_bad);
   end

   assign rd_err   = err_q;
   assign addr_err = err_q;
`else
   logic unused_addr_msbs;

   assign if_bad           = 1'b0;
   assign ld_bad           = 1'b0;
   assign rd_err           = 1'b0;
   assign unused_addr_msbs = ^{if_addr[ADDR_WIDTH-1:MW+2], ld_addr[ADDR_WIDTH-1:MW+2]};
`endif

   // Grants are masked during reset so every output is quiet while resetn is low.
   always_comb begin
      if_gnt = resetn && if_req && (!ld_req || burst_full);
      ld_gnt = resetn && ld_req && !(if_req && burst_full);
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt && !if_bad) begin
         mem_en   = 1'b1;
         mem_addr = if_idx;
      end else if (ld_gnt && !ld_bad) begin
         mem_en    = 1'b1;
         mem_we    = ld_we;
         mem_addr  = ld_idx;
         mem_wdata = ld_wdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                  burst_cnt <= '0;
      else if (if_gnt || !if_req)   burst_cnt <= '0;
      else if (ld_gnt && !burst_full) burst_cnt <= burst_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rd_owner <= OWNER_NONE;
      else         rd_owner <= rd_owner_next;
   end

   always_comb begin
      rd_owner_next = OWNER_NONE;
      if (if_gnt)                rd_owner_next = OWNER_IF;
      else if (ld_gnt && !ld_we) rd_owner_next = OWNER_LD;
   end

   assign ret_data = rd_err ? NOP_INSTR : mem_rdata;

   always_comb begin
      if_rvalid = 1'b0;
      if_rdata  = '0;
      ld_rvalid = 1'b0;
      ld_rdata  = '0;
      case (rd_owner)
         OWNER_IF: begin
            if_rvalid = 1'b1;
            if_rdata  = ret_data;
         end
         OWNER_LD: begin
            ld_rvalid = 1'b1;
            ld_rdata  = ret_data;
         end
         default: ;
      endcase
   end

endmodule
